pipelined_addsub: RTL
=====================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined adder/subtractor. Next generation of the 32-bit ripple adder used in the RV32 datapath.
- Splits a WIDTH-bit add into STAGES ripple chunks and registers the carry between chunks, so the adder can close timing at higher clock rates.
- Adds subtract mode, carry-out, signed-overflow and zero flags, and a valid/ready handshake on both sides.
- Intended for the ALU/address path of pipelined core variants.

Parameters:
- WIDTH, 32, operand and result width in bits; must be at least 2.
- STAGES, 4, number of pipeline stages; must divide WIDTH exactly; CHUNK = WIDTH/STAGES bits are added per stage.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept an operand set this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = a+b+c_in; 1 = a-b (a + ~b + 1, c_in ignored).
- c_in  in  1  carry-in for add mode.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  downstream accepts the result this cycle.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of the MSB; in subtract mode, 1 = no borrow.
- overflow  out  1  signed overflow of the operation.
- zero  out  1  sum == 0.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: on a rising edge with rst=1:
  - all stage valid bits and all data/carry registers clear to 0;
  - out_valid=0, sum=0, c_out=0, overflow=0, zero=0;
  - in_ready=1 from the first cycle after reset.
  - rst overrides a simultaneous accept.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance, combinational.
  - Accept occurs when in_valid && in_ready.
  - Result transfer occurs when out_valid && out_ready.
  - All stages shift together on advance. The pipeline uses a global stall; bubbles are not collapsed.
- Operand capture on accept:
  - b_eff = sub ? ~b : b.
  - cin_eff = sub ? 1 : c_in.
  - Stage 0 adds chunk 0 of a and b_eff with cin_eff.
  - Unprocessed upper chunks of a and b_eff travel forward in registers (skew buffer).
- Stage k (1..STAGES-1): adds chunk k using the registered carry from stage k-1. Completed lower sum chunks are carried forward alongside.
- Latency: STAGES cycles from accept to out_valid, with no stall. Throughput is one result per cycle.
- Flags, computed in the final stage and registered with sum:
  - c_out = carry out of bit WIDTH-1;
  - overflow = (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]);
  - zero = (sum == 0).
- Stall: while out_valid && !out_ready:
  - sum, c_out, overflow, zero and out_valid are held stable;
  - no internal stage changes;
  - in_ready=0.
- Valid bubbles:
  - when advance=1 and nothing is accepted, a 0 valid bit enters stage 0;
  - data registers of invalid stages are don't-care but must not reach the outputs while out_valid=0.
- Ordering: results leave in acceptance order. No result is dropped or duplicated.
- STAGES=1: single registered ripple adder with latency 1.
- Arithmetic: modulo 2^WIDTH. All carry chains are purely within-stage ripple; no `+` operator on the full WIDTH.
- Elaboration: WIDTH % STAGES != 0 or WIDTH < 2 is a fatal elaboration error.
- Reset mid-operation: all in-flight operations are discarded. out_valid=0 on the cycle after reset, and no stale result appears afterward.

Optional Feature:
- Macro: PIPELINED_ADDSUB_SAT_EN.
- When defined:
  - extra input port sat (1 bit) is captured with the operands and carried down the pipe;
  - if sat=1 and signed overflow occurs, sum clamps to 2^(WIDTH-1)-1 for positive overflow or -2^(WIDTH-1) for negative overflow;
  - overflow still reports the raw overflow; zero is computed on the clamped sum;
  - clamping is applied in the final stage with no added latency.
- When undefined: the sat port does not exist, and results always wrap.

Test Plan:
1. WIDTH=32, STAGES=4; a=0xFFFFFFFF, b=1, sub=0, c_in=0 accepted at cycle 0 -> out_valid at cycle 4 with sum=0x00000000, c_out=1, zero=1, overflow=0.
2. a=5, b=7, sub=1 -> sum=0xFFFFFFFE, c_out=0, overflow=0, zero=0. Then a=7, b=5, sub=1 -> sum=2, c_out=1.
3. a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, overflow=1. With PIPELINED_ADDSUB_SAT_EN and sat=1 -> sum=0x7FFFFFFF, overflow=1.
4. Eight back-to-back random operations with out_ready=1 -> results on cycles 4..11, consecutive, in order, each matching a golden model. Also sweep WIDTH=8/STAGES=2 and WIDTH=64/STAGES=8.
5. Pipeline full, out_ready=0 for 3 cycles -> in_ready=0, outputs bit-stable. After out_ready=1, all queued results are delivered with none lost or duplicated.
6. Accept 2 operations, assert rst for 1 cycle at cycle 2 -> out_valid=0 and all outputs 0 from cycle 3. No result emitted for the discarded operations; a new operation after reset completes in 4 cycles.

Source files
------------

// File: rtl/pipelined_addsub_if.sv
// Operand/result bundle for pipelined_addsub: upstream operand handshake plus
// downstream result handshake with flags. master = producer/consumer side, slave = the adder.
// Ports: in_valid/in_ready, a, b, sub, c_in (sat if PIPELINED_ADDSUB_SAT_EN), out_valid/out_ready, sum, c_out, overflow, zero.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             c_in;
`ifdef PIPELINED_ADDSUB_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             zero;

`ifdef PIPELINED_ADDSUB_SAT_EN
  modport master (output in_valid, a, b, sub, c_in, sat, out_ready,
                  input  in_ready, out_valid, sum, c_out, overflow, zero);
  modport slave  (input  in_valid, a, b, sub, c_in, sat, out_ready,
                  output in_ready, out_valid, sum, c_out, overflow, zero);
`else
  modport master (output in_valid, a, b, sub, c_in, out_ready,
                  input  in_ready, out_valid, sum, c_out, overflow, zero);
  modport slave  (input  in_valid, a, b, sub, c_in, out_ready,
                  output in_ready, out_valid, sum, c_out, overflow, zero);
`endif
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: WIDTH-bit ripple add split into STAGES chunks, carry registered between chunks.
// Latency STAGES cycles, one result per cycle; sum/c_out/overflow/zero registered together in the last stage.
// Backpressure: global stall, in_ready = !out_valid || out_ready; the whole pipe freezes while the output is held.
// Ports: clk, rst (synchronous, active-high), io (pipelined_addsub_if.slave).
// Optional: define PIPELINED_ADDSUB_SAT_EN to add the sat input (clamp sum on signed overflow).
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               rst,
  pipelined_addsub_if.slave  io
);

  localparam int CHUNK = (STAGES > 0) ? WIDTH / STAGES : 1;
  localparam int NP    = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int MSB   = WIDTH - 1;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $fatal(1, "pipelined_addsub: WIDTH must be >= 2 and an exact multiple of STAGES");
  end

  // One pipeline slot: operands travel whole (skew buffer), s fills in chunk by chunk,
  // cy is the carry out of the most recently completed chunk.
  typedef struct packed {
    logic             vld;
    logic             sat;
    logic             cy;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stg_t;

  logic                advance;
  logic                accept;
  stg_t                in_st;
  stg_t [NP-1:0]       pipe_q;
  stg_t [STAGES-1:0]   stg_d;
  stg_t                fin;

  logic                out_vld_q;
  logic [WIDTH-1:0]    sum_q;
  logic                c_out_q;
  logic                ovf_q;
  logic                zero_q;

  logic [WIDTH-1:0]    sum_d;
  logic                ovf_raw;
  logic                unused_fin;

  assign advance     = !out_vld_q || io.out_ready;
  assign accept      = io.in_valid && advance;
  assign io.in_ready = advance;

  // Subtract is a + ~b + 1; c_in only matters in add mode.
  always_comb begin
    in_st     = '0;
    in_st.vld = accept;
    in_st.cy  = io.sub ? 1'b1 : io.c_in;
    in_st.a   = io.a;
    in_st.b   = io.sub ? ~io.b : io.b;
`ifdef PIPELINED_ADDSUB_SAT_EN
    in_st.sat = io.sat;
`endif
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stg_t           src;
    stg_t           nxt;
    logic [CHUNK:0] cy;

    if (k == 0) begin : g_first
      assign src = in_st;
    end else begin : g_rest
      assign src = pipe_q[k-1];
    end

    // Bit-level ripple across this stage's chunk only.
    always_comb begin
      nxt   = src;
      cy    = '0;
      cy[0] = src.cy;
      for (int i = 0; i < CHUNK; i++) begin
        nxt.s[k*CHUNK+i] = src.a[k*CHUNK+i] ^ src.b[k*CHUNK+i] ^ cy[i];
        cy[i+1]          = (src.a[k*CHUNK+i] & src.b[k*CHUNK+i]) |
                           (cy[i] & (src.a[k*CHUNK+i] ^ src.b[k*CHUNK+i]));
      end
      nxt.cy = cy[CHUNK];
    end

    assign stg_d[k] = nxt;
  end

  assign fin = stg_d[STAGES-1];

  // Flags on the raw result; clamping (if enabled) only changes what is stored as sum.
  always_comb begin
    ovf_raw = (fin.a[MSB] == fin.b[MSB]) && (fin.s[MSB] != fin.a[MSB]);
    sum_d   = fin.s;
`ifdef PIPELINED_ADDSUB_SAT_EN
    if (fin.sat && ovf_raw) begin
      // Both operands negative -> clamp to most negative, otherwise most positive.
      sum_d = fin.a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Consumed operand bits of the last slot (and sat when clamping is compiled out) have no reader.
  assign unused_fin = ^fin;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q    <= '0;
      out_vld_q <= 1'b0;
      sum_q     <= '0;
      c_out_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        pipe_q[k] <= stg_d[k];
      end
      // Bubbles load zeros so don't-care slot data never shows on the outputs.
      out_vld_q <= fin.vld;
      sum_q     <= fin.vld ? sum_d : '0;
      c_out_q   <= fin.vld & fin.cy;
      ovf_q     <= fin.vld & ovf_raw;
      zero_q    <= fin.vld & ~|sum_d;
    end
  end

  assign io.out_valid = out_vld_q;
  assign io.sum       = sum_q;
  assign io.c_out     = c_out_q;
  assign io.overflow  = ovf_q;
  assign io.zero      = zero_q;

endmodule
